// File: rtl/deposito_bomba.sv
// Water-tank pump controller: accepts a dose request on the BombaAgua rising edge.
// It waits for the heater, then pumps one unit every CICLOS_POR_UNIDADE cycles and deducts each unit from the tank level.
module deposito_bomba #(
  parameter int CAPACIDADE         = 20,
  parameter int CICLOS_POR_UNIDADE = 2,
  parameter int TIMEOUT_AQUECER    = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BombaAgua,
  input  logic [3:0] TempoDeAgua,
  input  logic       Termobloco,
  input  logic       Refill,
  output logic       Valvula,
  output logic       Concluido,
  output logic [4:0] NivelDeposito,
  output logic       DepositoVazio,
  output logic       Erro,
  output logic [1:0] EstadoBomba
);

  localparam int WW = $clog2(TIMEOUT_AQUECER + 1) + 1;

  typedef enum logic [1:0] {
    REPOUSO        = 2'b00,
    ESPERA_AQUECER = 2'b01,
    BOMBEAR        = 2'b10,
    ERRO           = 2'b11
  } estado_t;

  estado_t       state_q, state_d;
  logic [4:0]    lvl_q, lvl_d;
  logic [3:0]    dose_q, dose_d;
  logic [3:0]    sub_q, sub_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          bomba_q;
  logic          conc_q, conc_d;
  logic          rise;

  assign rise = BombaAgua & ~bomba_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= REPOUSO;
      lvl_q   <= 5'(CAPACIDADE);
      dose_q  <= '0;
      sub_q   <= '0;
      wait_q  <= '0;
      bomba_q <= 1'b0;
      conc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dose_q  <= dose_d;
      sub_q   <= sub_d;
      wait_q  <= wait_d;
      bomba_q <= BombaAgua;
      conc_q  <= conc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    dose_d  = dose_q;
    sub_d   = sub_q;
    wait_d  = wait_q;
    conc_d  = 1'b0;
    // Refill is honoured everywhere except while the pump is running.
    if (Refill && state_q != BOMBEAR) lvl_d = 5'(CAPACIDADE);
    case (state_q)
      REPOUSO: begin
        sub_d  = '0;
        wait_d = '0;
        if (rise) begin
          dose_d = TempoDeAgua;
          // Compared against the pre-refill level even when Refill coincides.
          if (TempoDeAgua == 4'd0)                  conc_d  = 1'b1;
          else if ({1'b0, TempoDeAgua} > lvl_q)     state_d = ERRO;
          else if (Termobloco)                      state_d = BOMBEAR;
          else                                      state_d = ESPERA_AQUECER;
        end
      end
      ESPERA_AQUECER: begin
        if (!BombaAgua)                             state_d = REPOUSO;
        else if (Termobloco)                        state_d = BOMBEAR;
        else if (wait_q == WW'(TIMEOUT_AQUECER))    state_d = ERRO;
        else                                        wait_d  = wait_q + 1'b1;
      end
      BOMBEAR: begin
        if (!BombaAgua) begin
          state_d = REPOUSO;
          sub_d   = '0;
        end else if (sub_q == 4'(CICLOS_POR_UNIDADE - 1)) begin
          sub_d  = '0;
          lvl_d  = (lvl_q == 5'd0) ? 5'd0 : lvl_q - 5'd1;
          dose_d = (dose_q == 4'd0) ? 4'd0 : dose_q - 4'd1;
          if (dose_q <= 4'd1) begin
            conc_d  = 1'b1;
            state_d = REPOUSO;
          end
        end else begin
          sub_d = sub_q + 4'd1;
        end
      end
      ERRO: begin
        wait_d = '0;
        if (Refill) state_d = REPOUSO;
      end
      default: state_d = REPOUSO;
    endcase
  end

  assign Valvula       = (state_q == BOMBEAR);
  assign Erro          = (state_q == ERRO);
  assign EstadoBomba   = state_q;
  assign NivelDeposito = lvl_q;
  assign DepositoVazio = (lvl_q == 5'd0);
  assign Concluido     = conc_q;

endmodule

// File: tb/tb_deposito_bomba.sv
// Directed bench for deposito_bomba: a vector table for basic dosing plus hand sequences for waiting, errors and aborts.
module tb_deposito_bomba;

  logic       Clock = 1'b0;
  logic       Reset, BombaAgua, Termobloco, Refill;
  logic [3:0] TempoDeAgua;
  logic       Valvula, Concluido, DepositoVazio, Erro;
  logic [4:0] NivelDeposito;
  logic [1:0] EstadoBomba;

  int errors = 0;
  int checks = 0;

  deposito_bomba #(.CAPACIDADE(20), .CICLOS_POR_UNIDADE(2), .TIMEOUT_AQUECER(15)) dut (
    .Clock(Clock), .Reset(Reset), .BombaAgua(BombaAgua), .TempoDeAgua(TempoDeAgua),
    .Termobloco(Termobloco), .Refill(Refill), .Valvula(Valvula), .Concluido(Concluido),
    .NivelDeposito(NivelDeposito), .DepositoVazio(DepositoVazio), .Erro(Erro),
    .EstadoBomba(EstadoBomba)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst, bomba, termo, refill;
    logic [3:0] dose;
    logic [1:0] est;
    logic       valv, conc;
    logic [4:0] niv;
  } vec_t;

  vec_t tbl[16];

  task automatic step(input logic r, input logic b, input logic t, input logic f, input logic [3:0] d);
    Reset = r; BombaAgua = b; Termobloco = t; Refill = f; TempoDeAgua = d;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] est, input logic valv,
                       input logic conc, input logic [4:0] niv);
    logic [9:0] got, exp;
    got = {EstadoBomba, Valvula, Concluido, NivelDeposito, DepositoVazio, Erro};
    exp = {est, valv, conc, niv, (niv == 5'd0), (est == 2'b11)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got est=%0d valv=%0b conc=%0b niv=%0d vazio=%0b erro=%0b, want est=%0d valv=%0b conc=%0b niv=%0d vazio=%0b erro=%0b",
               nm, EstadoBomba, Valvula, Concluido, NivelDeposito, DepositoVazio, Erro,
               est, valv, conc, niv, (niv == 5'd0), (est == 2'b11));
    end
  endtask

  // Full pump cycle with heater ready: Valvula high for 2*d cycles, then a Concluido pulse.
  task automatic run_dose(input logic [3:0] d, input logic [4:0] start);
    logic [4:0] lv;
    step(0, 0, 1, 0, d);
    step(0, 1, 1, 0, d);
    check("dose_start", 2'b10, 1, 0, start);
    lv = start;
    for (int i = 1; i < 2 * d; i++) begin
      step(0, 1, 1, 0, d);
      if (i % 2 == 0) lv = lv - 5'd1;
      check("dose_run", 2'b10, 1, 0, lv);
    end
    step(0, 1, 1, 0, d);
    check("dose_done", 2'b00, 0, 1, start - 5'(d));
    step(0, 0, 1, 0, d);
  endtask

  initial begin
    //          rst bom ter ref dose  est  v  c  niv
    tbl[0]  = '{1, 0, 0, 0, 4'd0, 2'b00, 0, 0, 5'd20};
    tbl[1]  = '{0, 0, 1, 0, 4'd3, 2'b00, 0, 0, 5'd20};
    tbl[2]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd20};
    tbl[3]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd20};
    tbl[4]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd19};
    tbl[5]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd19};
    tbl[6]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd18};
    tbl[7]  = '{0, 1, 1, 0, 4'd3, 2'b10, 1, 0, 5'd18};
    tbl[8]  = '{0, 1, 1, 0, 4'd3, 2'b00, 0, 1, 5'd17};
    tbl[9]  = '{0, 1, 1, 0, 4'd3, 2'b00, 0, 0, 5'd17};
    tbl[10] = '{0, 0, 1, 0, 4'd0, 2'b00, 0, 0, 5'd17};
    tbl[11] = '{0, 1, 1, 0, 4'd0, 2'b00, 0, 1, 5'd17};
    tbl[12] = '{0, 1, 1, 0, 4'd0, 2'b00, 0, 0, 5'd17};
    tbl[13] = '{0, 0, 1, 0, 4'd0, 2'b00, 0, 0, 5'd17};
    tbl[14] = '{0, 0, 0, 1, 4'd0, 2'b00, 0, 0, 5'd20};
    tbl[15] = '{0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 5'd20};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].bomba, tbl[i].termo, tbl[i].refill, tbl[i].dose);
      check($sformatf("vec%0d", i), tbl[i].est, tbl[i].valv, tbl[i].conc, tbl[i].niv);
    end

    // Heater not ready: four waiting cycles, then four pumping cycles.
    step(0, 0, 0, 0, 4'd2);
    step(0, 1, 0, 0, 4'd2);
    check("wait1", 2'b01, 0, 0, 5'd20);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 4'd2);
      check("wait", 2'b01, 0, 0, 5'd20);
    end
    step(0, 1, 1, 0, 4'd2);
    check("heat_pump1", 2'b10, 1, 0, 5'd20);
    step(0, 1, 1, 0, 4'd2);
    check("heat_pump2", 2'b10, 1, 0, 5'd20);
    step(0, 1, 1, 0, 4'd2);
    check("heat_pump3", 2'b10, 1, 0, 5'd19);
    step(0, 1, 1, 0, 4'd2);
    check("heat_pump4", 2'b10, 1, 0, 5'd19);
    step(0, 1, 1, 0, 4'd2);
    check("heat_done", 2'b00, 0, 1, 5'd18);
    step(0, 0, 1, 0, 4'd2);

    // Abort after three pumping cycles: one unit deducted, no completion.
    step(0, 0, 1, 1, 4'd4);
    check("refill", 2'b00, 0, 0, 5'd20);
    step(0, 1, 1, 0, 4'd4);
    check("abort_p1", 2'b10, 1, 0, 5'd20);
    step(0, 1, 1, 0, 4'd4);
    step(0, 1, 1, 0, 4'd4);
    check("abort_p3", 2'b10, 1, 0, 5'd19);
    step(0, 0, 1, 0, 4'd4);
    check("abort", 2'b00, 0, 0, 5'd19);
    step(0, 0, 1, 0, 4'd4);
    check("abort_noconc", 2'b00, 0, 0, 5'd19);

    // Drain to 5, then an oversize request errors out until refill.
    run_dose(4'd7, 5'd19);
    run_dose(4'd7, 5'd12);
    step(0, 1, 1, 0, 4'd8);
    check("oversize", 2'b11, 0, 0, 5'd5);
    step(0, 0, 1, 0, 4'd8);
    check("erro_hold", 2'b11, 0, 0, 5'd5);
    step(0, 0, 1, 1, 4'd0);
    check("erro_refill", 2'b00, 0, 0, 5'd20);

    // Heater timeout: 16 waiting cycles, then error.
    step(0, 0, 0, 0, 4'd1);
    step(0, 1, 0, 0, 4'd1);
    check("to_w1", 2'b01, 0, 0, 5'd20);
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 0, 4'd1);
      check("to_wait", 2'b01, 0, 0, 5'd20);
    end
    step(0, 1, 0, 0, 4'd1);
    check("timeout", 2'b11, 0, 0, 5'd20);
    step(0, 0, 0, 1, 4'd1);
    check("to_refill", 2'b00, 0, 0, 5'd20);

    // Reset in the middle of pumping.
    step(0, 0, 1, 0, 4'd5);
    step(0, 1, 1, 0, 4'd5);
    step(0, 1, 1, 0, 4'd5);
    step(0, 1, 1, 0, 4'd5);
    check("pre_reset", 2'b10, 1, 0, 5'd19);
    step(1, 1, 1, 0, 4'd5);
    check("mid_reset", 2'b00, 0, 0, 5'd20);
    step(0, 0, 1, 0, 4'd5);
    check("post_reset", 2'b00, 0, 0, 5'd20);

    // Drain to empty, then even a one-unit request errors.
    run_dose(4'd15, 5'd20);
    run_dose(4'd5, 5'd5);
    check("empty", 2'b00, 0, 0, 5'd0);
    step(0, 1, 1, 0, 4'd1);
    check("empty_req", 2'b11, 0, 0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deposito_bomba.md
DEPOSITO_BOMBA -- requirements
Module: deposito_bomba

Interface
REQ-001 SHALL have parameter CAPACIDADE, default 20: tank capacity in dose units (1..31).
REQ-002 SHALL have parameter CICLOS_POR_UNIDADE, default 2: Clock cycles of pumping per dose unit (1..15).
REQ-003 SHALL have parameter TIMEOUT_AQUECER, default 15: maximum wait cycles for Termobloco before error.
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 SHALL have port: Clock  input  1  rising-edge system clock.
REQ-006 SHALL have port: Reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port: BombaAgua  input  1  pump request level from the coffee machine.
REQ-008 SHALL have port: TempoDeAgua  input  4  requested dose in units, sampled at BombaAgua rising edge.
REQ-009 SHALL have port: Termobloco  input  1  heater-at-temperature flag.
REQ-010 SHALL have port: Refill  input  1  tank-refilled pulse.
REQ-011 SHALL have port: Valvula  output  1  pump motor drive.
REQ-012 SHALL have port: Concluido  output  1  one-cycle dose-complete pulse.
REQ-013 SHALL have port: NivelDeposito  output  5  current tank level in units.
REQ-014 SHALL have port: DepositoVazio  output  1  high when NivelDeposito == 0.
REQ-015 SHALL have port: Erro  output  1  high while in state ERRO.
REQ-016 SHALL have port: EstadoBomba  output  2  current FSM state encoding.

Function
REQ-017 SHALL implement FSM states REPOUSO=00, ESPERA_AQUECER=01, BOMBEAR=10, ERRO=11, registered; EstadoBomba = state register.
REQ-018 SHALL detect BombaAgua rising edge via a registered copy; requests are only accepted in REPOUSO; edges in other states are ignored.
REQ-019 SHALL, on accepted edge, latch TempoDeAgua into a 4-bit remaining-dose counter the same cycle.
REQ-020 SHALL, on accepted edge with TempoDeAgua == 0, pulse Concluido next cycle and stay in REPOUSO.
REQ-021 SHALL, on accepted edge with TempoDeAgua > NivelDeposito, go to ERRO next cycle; level unchanged.
REQ-022 SHALL otherwise go to BOMBEAR if Termobloco == 1, else to ESPERA_AQUECER, next cycle.
REQ-023 SHALL, in ESPERA_AQUECER, go to BOMBEAR on the cycle Termobloco == 1, to REPOUSO if BombaAgua == 0, and to ERRO after TIMEOUT_AQUECER+1 consecutive waiting cycles; BombaAgua drop has priority over timeout.
REQ-024 SHALL drive Valvula = 1 exactly while state == BOMBEAR (decoded from registered state).
REQ-025 SHALL, in BOMBEAR, count CICLOS_POR_UNIDADE cycles per unit; at the last cycle of each unit decrement NivelDeposito and remaining dose by 1 and restart the sub-counter.
REQ-026 SHALL, when remaining dose reaches 0, assert Concluido for exactly one cycle and enter REPOUSO; Valvula high for exactly dose*CICLOS_POR_UNIDADE cycles.
REQ-027 SHALL, if BombaAgua == 0 during BOMBEAR, enter REPOUSO next cycle without Concluido; only completed units are deducted from the level.
REQ-028 SHALL treat Refill == 1 in REPOUSO, ESPERA_AQUECER or ERRO as setting NivelDeposito to CAPACIDADE next cycle; Refill in BOMBEAR is ignored.
REQ-029 SHALL leave ERRO only on Refill == 1, going to REPOUSO; Refill and BombaAgua edge in the same REPOUSO cycle: refill applied, request evaluated against the pre-refill level.
REQ-030 SHALL never underflow NivelDeposito; saturate at 0.

Reset
REQ-031 SHALL, when Reset == 1 at a rising Clock edge, set state REPOUSO, NivelDeposito = CAPACIDADE, all counters 0, Valvula/Concluido/Erro = 0, edge register 0, regardless of current state (including mid-pump); Reset overrides all other inputs.

Verification
REQ-032 SHALL be checked: Reset 1 cycle -> EstadoBomba=00, NivelDeposito=20, Valvula=0, Concluido=0, Erro=0, DepositoVazio=0.
REQ-033 SHALL be checked: Termobloco=1, TempoDeAgua=3, BombaAgua 0->1 held -> Valvula high 6 cycles, one Concluido pulse, NivelDeposito=17, EstadoBomba back to 00.
REQ-034 SHALL be checked: Termobloco=0, dose 2, Termobloco raised after 4 cycles -> EstadoBomba=01 for 4 cycles, then 10 for 4 cycles, NivelDeposito=18.
REQ-035 SHALL be checked: NivelDeposito=5, dose 8 requested -> EstadoBomba=11, Erro=1, Valvula=0; Refill pulse -> NivelDeposito=20, EstadoBomba=00.
REQ-036 SHALL be checked: dose 4, BombaAgua dropped after 3 BOMBEAR cycles -> REPOUSO, no Concluido, NivelDeposito=19.
REQ-037 SHALL be checked: Termobloco held 0 with BombaAgua high 16 cycles -> ERRO; Reset asserted mid-BOMBEAR -> REPOUSO, NivelDeposito=20 next cycle.
